// File: rtl/icache_pkg.sv
// ============================================================================
// Module : icache_pkg
// Brief  : Shared state encoding and address-split helpers for icache_sa.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COMPARE  = 3'd1,
        MISS_REQ = 3'd2,
        REFILL   = 3'd3,
        RESPOND  = 3'd4
    } state_e;

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int word_bits(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int byte_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int tag_bits(input int addr_width, input int data_width,
                                    input int sets, input int block_words);
        return addr_width - index_bits(sets) - word_bits(block_words) - byte_bits(data_width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_sa_if.sv
// ============================================================================
// Module : icache_sa_if
// Brief  : Fetch-side and memory-side handshake bundle of the instruction cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface icache_sa_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  fence_i;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    // Cache side
    modport slave (
        input  req_valid, req_addr, fence_i, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_data, mem_req_valid, mem_req_addr
    );

    // IFU plus bus-adapter side
    modport master (
        output req_valid, req_addr, fence_i, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_data, mem_req_valid, mem_req_addr
    );
endinterface

`default_nettype wire

// File: rtl/icache_way_array.sv
// ============================================================================
// Module : icache_way_array
// Brief  : One cache way: valid bits, tag store and block data store.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_way_array
    import icache_pkg::*;
#(
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_BITS    = 25
) (
    input  wire                               clk,
    input  wire                               rst_n,
    input  wire                               inv_all,
    input  wire  [index_bits(SETS)-1:0]       rd_index,
    input  wire  [word_bits(BLOCK_WORDS)-1:0] rd_word,
    output logic                              rd_valid,
    output logic [TAG_BITS-1:0]               rd_tag,
    output logic [DATA_WIDTH-1:0]             rd_data,
    input  wire                               data_we,
    input  wire  [index_bits(SETS)-1:0]       wr_index,
    input  wire  [word_bits(BLOCK_WORDS)-1:0] wr_word,
    input  wire  [DATA_WIDTH-1:0]             wr_data,
    input  wire                               tag_we,
    input  wire  [index_bits(SETS)-1:0]       tag_index,
    input  wire  [TAG_BITS-1:0]               tag_data
);
    logic [SETS-1:0]       valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS*BLOCK_WORDS];

    // Global invalidate wins over a same-cycle line fill
    always_comb begin
        valid_d = valid_q;
        if (tag_we)  valid_d[tag_index] = 1'b1;
        if (inv_all) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (tag_we)  tag_mem[tag_index]            <= tag_data;
        if (data_we) data_mem[{wr_index, wr_word}] <= wr_data;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

`default_nettype wire

// File: rtl/icache_sa.sv
// ============================================================================
// Module : icache_sa
// Brief  : 1/2-way set-associative I-cache with LRU, block refill and fence.i.
//          Define ICACHE_PERF_EN to build the hit/miss counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_sa
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SETS        = 8,
    parameter int WAYS        = 2,
    parameter int BLOCK_WORDS = 4
) (
    input  wire         clk,
    input  wire         rst_n,
    icache_sa_if.slave  bus,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int INDEX_BITS = index_bits(SETS);
    localparam int WORD_BITS  = word_bits(BLOCK_WORDS);
    localparam int BYTE_BITS  = byte_bits(DATA_WIDTH);
    localparam int TAG_BITS   = tag_bits(ADDR_WIDTH, DATA_WIDTH, SETS, BLOCK_WORDS);
    localparam int OFF_BITS   = WORD_BITS + BYTE_BITS;
    localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(BLOCK_WORDS - 1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [WORD_BITS-1:0]   beat_q, beat_d;
    logic                   victim_q, victim_d;
    logic                   fence_pend_q, fence_pend_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0]  mem_req_addr_q, mem_req_addr_d;

    logic [INDEX_BITS-1:0]  idx;
    logic [WORD_BITS-1:0]   word;
    logic [TAG_BITS-1:0]    tag;
    logic                   way_valid [2];
    logic [TAG_BITS-1:0]    way_tag   [2];
    logic [DATA_WIDTH-1:0]  way_data  [2];
    logic [1:0]             data_we, tag_we;
    logic                   inv_all, lru_rd, lru_we, lru_val;
    logic                   hit, hit_way, victim, req_ready;
    logic                   unused_addr;

    assign idx         = addr_q[OFF_BITS +: INDEX_BITS];
    assign word        = addr_q[BYTE_BITS +: WORD_BITS];
    assign tag         = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign unused_addr = ^addr_q[BYTE_BITS-1:0];

    // Ways beyond WAYS are tied off as permanently invalid
    for (genvar w = 0; w < 2; w++) begin : g_way
        if (w < WAYS) begin : g_inst
            icache_way_array #(
                .SETS        (SETS),
                .BLOCK_WORDS (BLOCK_WORDS),
                .DATA_WIDTH  (DATA_WIDTH),
                .TAG_BITS    (TAG_BITS)
            ) u_way (
                .clk       (clk),
                .rst_n     (rst_n),
                .inv_all   (inv_all),
                .rd_index  (idx),
                .rd_word   (word),
                .rd_valid  (way_valid[w]),
                .rd_tag    (way_tag[w]),
                .rd_data   (way_data[w]),
                .data_we   (data_we[w]),
                .wr_index  (idx),
                .wr_word   (beat_q),
                .wr_data   (bus.mem_rsp_data),
                .tag_we    (tag_we[w]),
                .tag_index (idx),
                .tag_data  (tag)
            );
        end else begin : g_tie
            logic unused_we;
            assign way_valid[w] = 1'b0;
            assign way_tag[w]   = '0;
            assign way_data[w]  = '0;
            assign unused_we    = data_we[w] ^ tag_we[w];
        end
    end

    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] lru_q, lru_d;
        always_comb begin
            lru_d = lru_q;
            if (lru_we) lru_d[idx] = lru_val;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) lru_q <= '0;
            else        lru_q <= lru_d;
        end
        assign lru_rd = lru_q[idx];
    end else begin : g_no_lru
        logic unused_lru;
        assign lru_rd     = 1'b0;
        assign unused_lru = lru_we ^ lru_val;
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (way_valid[w] && way_tag[w] == tag) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
        if (!way_valid[0])                   victim = 1'b0;
        else if (WAYS == 2 && !way_valid[1]) victim = 1'b1;
        else                                 victim = lru_rd;
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        beat_d          = beat_q;
        victim_d        = victim_q;
        fence_pend_d    = fence_pend_q;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = rsp_data_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        data_we         = 2'b00;
        tag_we          = 2'b00;
        inv_all         = 1'b0;
        lru_we          = 1'b0;
        lru_val         = 1'b0;
        req_ready       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fence_i || fence_pend_q) begin
                    inv_all      = 1'b1;
                    fence_pend_d = 1'b0;
                end else begin
                    req_ready = 1'b1;
                    if (bus.req_valid) begin
                        addr_d  = bus.req_addr;
                        state_d = COMPARE;
                    end
                end
            end
            COMPARE: begin
                if (hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = way_data[hit_way];
                    lru_we      = 1'b1;
                    lru_val     = ~hit_way;
                    state_d     = IDLE;
                end else begin
                    victim_d        = victim;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = {addr_q[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
                    state_d         = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    beat_d          = '0;
                    state_d         = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_rsp_valid) begin
                    data_we[victim_q] = 1'b1;
                    beat_d            = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        tag_we[victim_q] = 1'b1;
                        lru_we           = 1'b1;
                        lru_val          = ~victim_q;
                        state_d          = RESPOND;
                    end
                end
            end
            RESPOND: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = way_data[victim_q];
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A fence seen mid-transaction is deferred to the next IDLE cycle
        if (bus.fence_i && state_q != IDLE) fence_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            beat_q          <= '0;
            victim_q        <= 1'b0;
            fence_pend_q    <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            beat_q          <= beat_d;
            victim_q        <= victim_d;
            fence_pend_q    <= fence_pend_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == COMPARE) begin
            if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
            else     miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_sa.sv
// ============================================================================
// Module : tb_icache_sa
// Brief  : Directed plus random fetch bench for icache_sa against an LRU set model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_icache_sa;
    localparam int MODEL_WAYS = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] hit_cnt, miss_cnt;
    int          total, bad, n_hits, n_misses;
    logic [31:0] mdl [8][$];

    icache_sa_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    icache_sa #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .SETS        (8),
        .WAYS        (2),
        .BLOCK_WORDS (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if ((a & 32'hFFFF_FFF0) == 32'h8000_0000) return 32'hA0 + {28'd0, a[3:2]};
        return {a[15:2], 2'b01, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 8; s++) mdl[s].delete();
    endtask

    task automatic chk_perf();
`ifdef ICACHE_PERF_EN
        chk("hit_cnt", hit_cnt, n_hits);
        chk("miss_cnt", miss_cnt, n_misses);
`else
        chk("hit_cnt_tied", hit_cnt, 0);
        chk("miss_cnt_tied", miss_cnt, 0);
`endif
    endtask

    // Entered and left on a negedge with the cache idle
    task automatic fetch(input logic [31:0] a, input int stall, input bit fence_mid);
        logic [31:0] blk, exp_data, held;
        int          set, pos, n;
        bit          exp_hit, saw_miss;
        blk      = a & 32'hFFFF_FFF0;
        set      = int'(a[6:4]);
        exp_data = mem_rd(a);
        pos      = -1;
        for (int i = 0; i < mdl[set].size(); i++) if (mdl[set][i] == blk) pos = i;
        exp_hit = (pos >= 0);
        n = 0;
        #1;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        chk("req_ready_wait", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom();
        @(negedge clk);
        saw_miss = (bus.mem_req_valid === 1'b1);
        chk("hit_or_miss", saw_miss, !exp_hit);
        if (saw_miss) begin
            chk("mem_req_addr", bus.mem_req_addr, blk);
            held = bus.mem_req_addr;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("mreq_hold", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, held});
            end
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            chk("mreq_drop", bus.mem_req_valid, 0);
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = mem_rd(blk + 32'(4 * b));
                if (fence_mid && b == 1) bus.fence_i = 1'b1;
                @(negedge clk);
                bus.mem_rsp_valid = 1'b0;
                bus.fence_i       = 1'b0;
                bus.mem_rsp_data  = $urandom();
            end
            chk("respond_gap", bus.rsp_valid, 0);
            @(negedge clk);
        end
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_data", bus.rsp_data, exp_data);
        if (exp_hit) begin
            mdl[set].delete(pos);
            n_hits++;
        end else begin
            if (mdl[set].size() == MODEL_WAYS) void'(mdl[set].pop_back());
            n_misses++;
        end
        mdl[set].push_front(blk);
        if (fence_mid && saw_miss) begin
            chk("fence_ready_low", bus.req_ready, 0);
            clear_model();
        end
        @(negedge clk);
        chk("rsp_pulse", bus.rsp_valid, 0);
        chk_perf();
    endtask

    initial begin
        logic [31:0] a;
        total = 0; bad = 0; n_hits = 0; n_misses = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.fence_i = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        clear_model();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_mreq_valid", bus.mem_req_valid, 0);
        chk("rst_mreq_addr", bus.mem_req_addr, 0);
        chk_perf();
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, then hits within the same block
        fetch(32'h8000_0004, 0, 1'b0);
        fetch(32'h8000_000C, 0, 1'b0);
        // Set-0 conflict sequence exercising LRU eviction
        fetch(32'h8000_0000, 0, 1'b0);
        fetch(32'h8000_0080, 0, 1'b0);
        fetch(32'h8000_0100, 0, 1'b0);
        fetch(32'h8000_0080, 0, 1'b0);
        fetch(32'h8000_0000, 0, 1'b0);
        // Bus back-pressure
        fetch(32'h8000_0204, 5, 1'b0);
        // Fence during refill, then refetch
        fetch(32'h8000_0308, 1, 1'b1);
        fetch(32'h8000_0308, 0, 1'b0);
        fetch(32'h8000_0308, 0, 1'b0);

        // Fence while idle drops req_ready in the same cycle
        #1;
        bus.fence_i = 1'b1;
        #1;
        chk("fence_idle_ready", bus.req_ready, 0);
        @(negedge clk);
        bus.fence_i = 1'b0;
        clear_model();
        #1;
        chk("fence_idle_after", bus.req_ready, 1);
        @(negedge clk);
        fetch(32'h8000_0308, 0, 1'b0);

        // Reset after two refill beats
        a = 32'h8000_0410;
        #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_mreq", bus.mem_req_valid, 1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = mem_rd(a + 32'(4 * b));
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_req_ready", bus.req_ready, 1);
        chk("rstmid_rsp_valid", bus.rsp_valid, 0);
        chk("rstmid_rsp_data", bus.rsp_data, 0);
        chk("rstmid_mreq_valid", bus.mem_req_valid, 0);
        chk("rstmid_mreq_addr", bus.mem_req_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        n_hits = 0;
        n_misses = 0;
        chk_perf();
        for (int b = 0; b < 2; b++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = $urandom();
            @(negedge clk);
            chk("late_beat_rsp", {bus.rsp_valid, bus.mem_req_valid}, 2'b00);
        end
        bus.mem_rsp_valid = 1'b0;
        fetch(a, 0, 1'b0);
        fetch(a + 32'h4, 0, 1'b0);

        // Random traffic over a small address pool to force conflicts
        for (int t = 0; t < 150; t++) begin
            a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 7)
                              | (32'($urandom_range(0, 7)) << 4)
                              | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 7) == 0) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = $urandom();
                @(negedge clk);
                bus.mem_rsp_valid = 1'b0;
                chk("stray_beat", bus.rsp_valid, 0);
            end
            if ($urandom_range(0, 11) == 0) begin
                #1;
                bus.fence_i = 1'b1;
                #1;
                chk("rand_fence_ready", bus.req_ready, 0);
                @(negedge clk);
                bus.fence_i = 1'b0;
                clear_model();
            end
            fetch(a, int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
